// File: rtl/weights_stream_ctrl.sv
`default_nettype none
// weights_stream_ctrl: burst read sequencer for port 2 of the weights RAM. It streams
// the returned words through a credit-limited FIFO onto a valid/ready output.
// Revision: 1.0
module weights_stream_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 11,
  parameter int FIFO_DEPTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address2,
  output logic              ram_chipselect2,
  output logic              ram_write2,
  output logic [3:0]        ram_byteenable2,
  output logic              ram_clken2,
  input  logic [DATA_W-1:0] ram_readdata2,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_popped;
  logic              r_inflight;
  logic              r_done;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr;
  logic [PTR_W-1:0]  r_rd;

  logic              w_accept;
  logic              w_zero;
  logic [CNT_W:0]    w_occ;
  logic              w_credit;
  logic              w_issue;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_last_beat;
  logic              w_fin;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits come only from registered occupancy, so m_ready never reaches the RAM port.
  assign w_accept    = (r_state == S_IDLE) & start & ~abort;
  assign w_zero      = (length == '0);
  assign w_occ       = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_credit    = w_occ < (CNT_W+1)'(FIFO_DEPTH);
  assign w_issue     = (r_state == S_RUN) & ~abort & (r_issued < r_len) & w_credit;
  assign w_valid     = (r_state == S_RUN) & (r_count != '0);
  assign w_pop       = w_valid & m_ready;
  assign w_push      = (r_state == S_RUN) & r_inflight;
  assign w_last_beat = (r_popped == r_len - LEN_W'(1));
  assign w_fin       = w_pop & w_last_beat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    busy            = (r_state != S_IDLE);
    done            = r_done;
    ram_address2    = r_cur_addr;
    ram_chipselect2 = w_issue;
    ram_write2      = 1'b0;
    ram_byteenable2 = 4'hF;
    ram_clken2      = 1'b1;
    m_data          = r_mem[r_rd];
    m_valid         = w_valid;
    m_last          = w_valid & w_last_beat;
    case (r_state)
      S_IDLE:  if (w_accept && !w_zero) w_state_nxt = S_RUN;
      S_RUN: begin
        if (abort)      w_state_nxt = S_FLUSH;
        else if (w_fin) w_state_nxt = S_IDLE;
      end
      S_FLUSH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_addr <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_popped   <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_zero) begin
              r_done <= 1'b1;
            end else begin
              r_cur_addr <= base_addr;
              r_len      <= length;
              r_issued   <= '0;
              r_popped   <= '0;
              r_inflight <= 1'b0;
              r_count    <= '0;
              r_wr       <= '0;
              r_rd       <= '0;
            end
          end
        end
        S_RUN: begin
          r_inflight <= w_issue;
          if (w_issue) begin
            r_cur_addr <= r_cur_addr + ADDR_W'(1);
            r_issued   <= r_issued + LEN_W'(1);
          end
          if (w_push) begin
            r_mem[r_wr] <= ram_readdata2;
            r_wr        <= f_next(r_wr);
          end
          if (w_pop) begin
            r_rd     <= f_next(r_rd);
            r_popped <= r_popped + LEN_W'(1);
          end
          case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
          endcase
          if (w_fin && !abort) r_done <= 1'b1;
        end
        S_FLUSH: begin
          // Late RAM returns and buffered words are dropped here.
          r_inflight <= 1'b0;
          r_count    <= '0;
          r_wr       <= '0;
          r_rd       <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_weights_stream_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// tb_weights_stream_ctrl: randomized self-checking bench; expected streams are derived
// from base/length arithmetic and a behavioural RAM whose word is a function of address.
module tb_weights_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic        busy;
  logic        done;
  logic [9:0]  ram_address2;
  logic        ram_chipselect2;
  logic        ram_write2;
  logic [3:0]  ram_byteenable2;
  logic        ram_clken2;
  logic [31:0] ram_readdata2 = 32'h0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  weights_stream_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .busy(busy), .done(done),
    .ram_address2(ram_address2), .ram_chipselect2(ram_chipselect2),
    .ram_write2(ram_write2), .ram_byteenable2(ram_byteenable2),
    .ram_clken2(ram_clken2), .ram_readdata2(ram_readdata2),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  function automatic logic [31:0] f_word(input logic [9:0] a);
    return {a, 12'h5A5, ~a};
  endfunction

  // Port B of the RAM: registered read, one cycle latency.
  always @(posedge clk) if (ram_clken2) ram_readdata2 <= f_word(ram_address2);

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 1) return (c < 3) ? 1'b1 : (c <= 12) ? 1'b0 : ((c - 13) % 2 == 0);
    if (mode == 2) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  logic [9:0]  q_cs_addr[$];
  int          q_cs_cyc[$];
  logic [31:0] q_data[$];
  logic        q_last[$];
  int          q_vcyc[$];
  logic        q_busy[$];
  logic        q_valid[$];
  int          q_done_cyc[$];
  int          occ_viol, stab_viol, max_occ, abort_cyc;
  bit          timed_out;

  // Drives one burst and records what the DUT did, cycle 0 being the start cycle.
  task automatic run_burst(input logic [9:0] b, input logic [10:0] n, input int mode,
                           input int abort_after, input bit poke, input int limit);
    int cyc, issued, popped, stop_at;
    bit stalled;
    logic [31:0] hd;
    logic hl;
    q_cs_addr.delete(); q_cs_cyc.delete(); q_data.delete(); q_last.delete();
    q_vcyc.delete(); q_busy.delete(); q_valid.delete(); q_done_cyc.delete();
    occ_viol = 0; stab_viol = 0; max_occ = 0; abort_cyc = -1; timed_out = 0;
    issued = 0; popped = 0; stop_at = -1; stalled = 0; hd = '0; hl = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = n; abort = 1'b0; m_ready = ready_for(mode, 0);
    cyc = 0;
    forever begin
      @(negedge clk);
      q_busy.push_back(busy);
      q_valid.push_back(m_valid);
      if (ram_chipselect2) begin
        if (issued - popped >= 3) occ_viol++;
        q_cs_addr.push_back(ram_address2);
        q_cs_cyc.push_back(cyc);
        issued++;
      end
      if (stalled && m_valid && (m_data !== hd || m_last !== hl)) stab_viol++;
      if (m_valid && m_ready) begin
        q_data.push_back(m_data); q_last.push_back(m_last); q_vcyc.push_back(cyc);
        popped++;
      end
      if (issued - popped > max_occ) max_occ = issued - popped;
      stalled = m_valid && !m_ready; hd = m_data; hl = m_last;
      if (done) begin
        q_done_cyc.push_back(cyc);
        if (stop_at < 0) stop_at = cyc + 2;
      end
      if (cyc == stop_at) break;
      if (cyc >= limit) begin timed_out = 1; break; end
      @(posedge clk); #1;
      cyc++;
      start     = poke && busy && ($urandom_range(0, 2) == 0);
      base_addr = 10'($urandom);
      length    = 11'($urandom);
      m_ready   = ready_for(mode, cyc);
      abort     = 1'b0;
      if (abort_after >= 0 && abort_cyc < 0 && popped >= abort_after) begin
        abort = 1'b1; abort_cyc = cyc; stop_at = cyc + 4;
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({busy, done, ram_chipselect2, m_valid, m_last} !== 5'b0) begin
      n_errors++; $display("FAIL reset_flags: got %b expected 00000",
                           {busy, done, ram_chipselect2, m_valid, m_last});
    end
    n_checks++;
    if (ram_address2 !== 10'h0) begin
      n_errors++; $display("FAIL reset_addr: got %h expected 000", ram_address2);
    end
    n_checks++;
    if (m_data !== 32'h0) begin
      n_errors++; $display("FAIL reset_data: got %h expected 0", m_data);
    end
    n_checks++;
    if ({ram_write2, ram_byteenable2, ram_clken2} !== 6'b0_1111_1) begin
      n_errors++; $display("FAIL ram_constants: got %b expected 011111",
                           {ram_write2, ram_byteenable2, ram_clken2});
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic();
    int bad, nl;
    run_burst(10'h010, 11'd4, 0, -1, 0, 100);
    n_checks++;
    if (timed_out || q_cs_cyc.size() != 4) begin
      n_errors++; $display("FAIL basic_cs_count: got %0d (timeout=%0d) expected 4",
                           q_cs_cyc.size(), timed_out);
    end
    bad = -1;
    for (int i = 0; i < q_cs_cyc.size(); i++)
      if ((q_cs_cyc[i] != i + 1 || q_cs_addr[i] !== 10'h010 + 10'(i)) && bad < 0) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_errors++; $display("FAIL basic_issue: beat %0d got addr %h cycle %0d expected addr %h cycle %0d",
                           bad, q_cs_addr[bad], q_cs_cyc[bad], 10'h010 + 10'(bad), bad + 1);
    end
    bad = -1; nl = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      if ((q_vcyc[i] != i + 3 || q_data[i] !== f_word(10'h010 + 10'(i))) && bad < 0) bad = i;
      if (q_last[i]) nl++;
    end
    n_checks++;
    if (q_data.size() != 4 || bad >= 0) begin
      n_errors++; $display("FAIL basic_stream: words %0d first bad %0d expected 4 words in cycles 3-6",
                           q_data.size(), bad);
    end
    n_checks++;
    if (nl != 1 || q_last[3] !== 1'b1) begin
      n_errors++; $display("FAIL basic_last: got %0d lasts expected 1 on beat 3", nl);
    end
    n_checks++;
    if (q_done_cyc.size() != 1 || q_done_cyc[0] != 7) begin
      n_errors++; $display("FAIL basic_done: got %0d pulses first at %0d expected 1 at 7",
                           q_done_cyc.size(), q_done_cyc.size() > 0 ? q_done_cyc[0] : -1);
    end
    n_checks++;
    if ({q_busy[0], q_busy[1], q_busy[6], q_busy[7]} !== 4'b0110) begin
      n_errors++; $display("FAIL basic_busy: cycles 0,1,6,7 got %b expected 0110",
                           {q_busy[0], q_busy[1], q_busy[6], q_busy[7]});
    end
  endtask

  task automatic test_wrap();
    int bad;
    run_burst(10'h3FE, 11'd4, 0, -1, 0, 100);
    bad = -1;
    for (int i = 0; i < q_cs_addr.size(); i++)
      if (q_cs_addr[i] !== 10'h3FE + 10'(i) && bad < 0) bad = i;
    n_checks++;
    if (q_cs_addr.size() != 4 || bad >= 0) begin
      n_errors++; $display("FAIL wrap_addr: %0d pulses first bad %0d expected 3FE,3FF,000,001",
                           q_cs_addr.size(), bad);
    end
    bad = -1;
    for (int i = 0; i < q_data.size(); i++)
      if (q_data[i] !== f_word(10'h3FE + 10'(i)) && bad < 0) bad = i;
    n_checks++;
    if (q_data.size() != 4 || bad >= 0) begin
      n_errors++; $display("FAIL wrap_data: %0d words first bad %0d expected 4 in order",
                           q_data.size(), bad);
    end
  endtask

  task automatic test_backpressure();
    int bad, nl;
    run_burst(10'h000, 11'd16, 1, -1, 1, 300);
    bad = -1; nl = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      if (q_data[i] !== f_word(10'(i)) && bad < 0) bad = i;
      if (q_last[i] && i != 15) nl++;
    end
    n_checks++;
    if (timed_out || q_data.size() != 16 || bad >= 0) begin
      n_errors++; $display("FAIL bp_order: %0d words first bad %0d expected 0..15", q_data.size(), bad);
    end
    n_checks++;
    if (occ_viol != 0 || max_occ != 3) begin
      n_errors++; $display("FAIL bp_credit: violations %0d peak %0d expected 0 and 3", occ_viol, max_occ);
    end
    n_checks++;
    if (stab_viol != 0) begin
      n_errors++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", stab_viol);
    end
    n_checks++;
    if (nl != 0 || q_cs_addr.size() != 16 || q_done_cyc.size() != 1) begin
      n_errors++; $display("FAIL bp_misc: stray lasts %0d reads %0d dones %0d expected 0,16,1",
                           nl, q_cs_addr.size(), q_done_cyc.size());
    end
  endtask

  task automatic test_zero_length();
    int nb, nv;
    run_burst(10'($urandom), 11'd0, 0, -1, 0, 20);
    nb = 0; nv = 0;
    foreach (q_busy[i]) begin if (q_busy[i]) nb++; if (q_valid[i]) nv++; end
    n_checks++;
    if (q_done_cyc.size() != 1 || q_done_cyc[0] != 1) begin
      n_errors++; $display("FAIL zero_done: got %0d pulses expected 1 in cycle 1", q_done_cyc.size());
    end
    n_checks++;
    if (nb != 0 || nv != 0 || q_cs_addr.size() != 0) begin
      n_errors++; $display("FAIL zero_quiet: busy %0d valid %0d reads %0d expected 0,0,0",
                           nb, nv, q_cs_addr.size());
    end
  endtask

  task automatic test_abort();
    int bad, late;
    logic [9:0] b;
    b = 10'($urandom);
    run_burst(b, 11'd8, 0, 2, 0, 100);
    n_checks++;
    if (timed_out || abort_cyc < 0 || q_valid[abort_cyc + 1] !== 1'b0) begin
      n_errors++; $display("FAIL abort_valid: m_valid after abort got %b expected 0",
                           abort_cyc < 0 ? 1'bx : q_valid[abort_cyc + 1]);
    end
    n_checks++;
    if (q_done_cyc.size() != 0 || q_busy[abort_cyc + 2] !== 1'b0) begin
      n_errors++; $display("FAIL abort_idle: dones %0d busy %b expected 0 and 0",
                           q_done_cyc.size(), q_busy[abort_cyc + 2]);
    end
    bad = -1; late = 0;
    foreach (q_data[i]) if (q_data[i] !== f_word(b + 10'(i)) && bad < 0) bad = i;
    foreach (q_cs_cyc[i]) if (q_cs_cyc[i] > abort_cyc) late++;
    n_checks++;
    if (q_data.size() < 2 || bad >= 0 || late != 0) begin
      n_errors++; $display("FAIL abort_prefix: words %0d bad %0d late reads %0d expected >=2,-1,0",
                           q_data.size(), bad, late);
    end
    run_burst(10'h100, 11'd2, 0, -1, 0, 50);
    n_checks++;
    if (q_data.size() != 2 || q_data[0] !== f_word(10'h100) || q_data[1] !== f_word(10'h101)
        || q_vcyc[0] != 3) begin
      n_errors++; $display("FAIL abort_restart: %0d words first %h expected 2 words from %h",
                           q_data.size(), q_data.size() > 0 ? q_data[0] : 32'h0, f_word(10'h100));
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] b;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'($urandom); length = 11'd20; m_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin
      n_errors++; $display("FAIL areset_pre: valid %b busy %b expected 1 1", m_valid, busy);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, ram_chipselect2, m_valid, m_last} !== 5'b0 || ram_address2 !== 10'h0
        || m_data !== 32'h0) begin
      n_errors++; $display("FAIL areset_outputs: flags %b addr %h data %h expected all 0",
                           {busy, done, ram_chipselect2, m_valid, m_last}, ram_address2, m_data);
    end
    @(negedge clk); reset = 1'b0;
    b = 10'($urandom);
    run_burst(b, 11'd5, 0, -1, 0, 50);
    n_checks++;
    if (q_data.size() != 5 || q_data[0] !== f_word(b) || q_data[4] !== f_word(b + 10'd4)
        || q_done_cyc.size() != 1) begin
      n_errors++; $display("FAIL areset_after: %0d words first %h expected 5 from %h",
                           q_data.size(), q_data.size() > 0 ? q_data[0] : 32'h0, f_word(b));
    end
  endtask

  task automatic test_random();
    int bad, nl;
    logic [9:0]  b;
    logic [10:0] n;
    for (int k = 0; k < 6; k++) begin
      b = 10'($urandom);
      n = 11'($urandom_range(1, 40));
      run_burst(b, n, 2, -1, 1, 1000);
      bad = -1; nl = 0;
      foreach (q_data[i]) begin
        if (q_data[i] !== f_word(b + 10'(i)) && bad < 0) bad = i;
        if (q_last[i]) nl++;
      end
      n_checks++;
      if (timed_out || q_data.size() != int'(n) || bad >= 0 || nl != 1 || q_last[n - 1] !== 1'b1
          || q_done_cyc.size() != 1 || occ_viol != 0 || stab_viol != 0) begin
        n_errors++; $display("FAIL random_burst%0d: base %h len %0d got %0d words bad %0d lasts %0d dones %0d occ %0d stab %0d",
                             k, b, n, q_data.size(), bad, nl, q_done_cyc.size(), occ_viol, stab_viol);
      end
    end
  endtask

  task automatic test_full_sweep();
    int bad, nl;
    logic [9:0] b;
    b = 10'($urandom);
    run_burst(b, 11'd1024, 2, -1, 1, 6000);
    bad = -1; nl = 0;
    foreach (q_data[i]) begin
      if (q_data[i] !== f_word(b + 10'(i)) && bad < 0) bad = i;
      if (q_last[i]) nl++;
    end
    n_checks++;
    if (timed_out || q_data.size() != 1024 || bad >= 0) begin
      n_errors++; $display("FAIL sweep_data: %0d words first bad %0d expected 1024 in order",
                           q_data.size(), bad);
    end
    n_checks++;
    if (nl != 1 || q_last[1023] !== 1'b1 || q_cs_addr.size() != 1024 || q_done_cyc.size() != 1) begin
      n_errors++; $display("FAIL sweep_last: lasts %0d reads %0d dones %0d expected 1,1024,1",
                           nl, q_cs_addr.size(), q_done_cyc.size());
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    base_addr = '0; length = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_abort();
    test_async_reset();
    test_random();
    test_full_sweep();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
